prod_accum: RTL and testbench
=============================

# prod_accum

Sequential accumulator directly downstream of the 3x3 unsigned array multiplier. It takes the multiplier's 6-bit products one per handshake and sums groups of N products into a dot-product result. Each finished result is presented on a valid/ready output port. A sticky overflow flag is kept per group.

## Interface
Parameters:
- N, 4, products per group; legal range 2..16
- ACC_W, 8, accumulator/result width; legal range 6..16
- CW, 4, counter width; must satisfy 2^CW >= N

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_prod is valid this cycle
- in_ready  output  1  block accepts a product this cycle
- in_prod  input  6  unsigned product from multiplier (0..49 in normal use; full 0..63 must be handled)
- flush  input  1  synchronous discard of the partial group
- out_valid  output  1  out_sum/out_ovf hold a finished result
- out_ready  input  1  consumer takes the result
- out_sum  output  ACC_W  group sum modulo 2^ACC_W
- out_ovf  output  1  a carry out of ACC_W occurred during the group

## Operation
- Clock and reset: one clock domain (clk). rst_n is asynchronous, active-low.
- States:
  - IDLE: entered on reset; left unconditionally on the first clk edge with rst_n high.
  - ACCUM: collecting products.
  - HOLD: result presented, waiting for the consumer.
- Transitions:
  - IDLE -> ACCUM.
  - ACCUM -> HOLD on the accepted beat that makes count reach N.
  - HOLD -> ACCUM on out_valid & out_ready.
- in_ready = 1 only in ACCUM. A beat is accepted when in_valid & in_ready.
- On an accepted beat:
  - sum is (ACC_W+1)-bit acc + zero-extended in_prod; acc <= sum[ACC_W-1:0].
  - ovf <= ovf | sum[ACC_W].
  - count <= count + 1.
- On the Nth beat, out_sum and out_ovf load from the same next-state values; out_valid <= 1.
- Handoff: in HOLD, out_valid & out_ready clears out_valid, acc, count and ovf on that edge.
- out_sum and out_ovf:
  - are stable while out_valid = 1;
  - retain their last value after the handoff.
- flush:
  - in ACCUM, flush = 1 clears acc, count and ovf. It has priority over a simultaneous in_valid, whose beat is dropped; in_ready is still 1, so upstream treats it as consumed.
  - in IDLE and HOLD, flush is ignored.
- Arithmetic: all operands unsigned; no saturation, the sum wraps.

## Timing
- Reset values (asserted asynchronously):
  - state IDLE; in_ready 0; out_valid 0; out_sum 0; out_ovf 0.
  - internal acc 0, count 0, ovf 0.
- in_ready rises on the first edge after rst_n deasserts.
- Latency: out_valid rises on the same edge that accepts the Nth product. It is visible the cycle after the Nth product was presented.
- Throughput: at most one result every N+1 cycles. in_ready = 0 for the whole of HOLD, including the handoff cycle; it returns to 1 the cycle after.
- Back-pressure: HOLD lasts indefinitely while out_ready = 0. No input is accepted and no data is lost.
- in_valid gaps: bubbles in ACCUM leave acc and count unchanged.
- rst_n low mid-group or in HOLD: the partial or pending result is discarded immediately and all reset values apply.
- Simultaneous flush and the Nth beat: flush wins; no result is produced and count returns to 0.

## Test plan
- Reset/idle:
  - stimulus: rst_n low, then released.
  - required: out_valid = 0, out_sum = 0, in_ready = 0 during reset; in_ready = 1 one edge after release.
- Basic group, N=4, ACC_W=8:
  - stimulus: products 49, 12, 0, 35, back-to-back, out_ready = 1.
  - required: out_sum = 96 and out_ovf = 0, with out_valid for exactly 1 cycle after the 4th beat; in_ready low for that cycle.
- Overflow, N=4, ACC_W=7:
  - stimulus: four products of 49.
  - required: out_sum = 68, out_ovf = 1; next group 1, 1, 1, 1 gives out_sum = 4, out_ovf = 0.
- Back-pressure:
  - stimulus: out_ready held 0 for 10 cycles after a group of 1, 2, 3, 4, with in_valid held high.
  - required: out_sum = 10 stable, in_ready = 0 for all 10 cycles, no beats accepted; first beat accepted the cycle after out_ready goes high.
- Flush:
  - stimulus: products 20, 30, then flush = 1 together with in_valid (in_prod = 7), then 1, 2, 3, 4.
  - required: out_sum = 10; the 7 is discarded.
- Async reset mid-group:
  - stimulus: products 5, 5, then rst_n pulsed low between clock edges.
  - required: all outputs return to reset values immediately; the next full group sums from 0.

Source files
------------

// File: rtl/prod_accum.sv
// prod_accum: sums groups of N multiplier products into a dot-product result
// with a sticky per-group carry flag, presented on a valid/ready port.
module prod_accum #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_prod,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    count;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             take;
  logic             last;
  logic             handoff;

  assign sum     = {1'b0, acc} + {{(ACC_W-5){1'b0}}, in_prod};
  assign accept  = in_valid & in_ready;
  assign take    = accept & ~flush;
  assign last    = (count == CW'(N-1));
  assign handoff = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = ACCUM;
      ACCUM: if (take && last) state_nx = HOLD;
      HOLD:  if (out_ready) state_nx = ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == ACCUM): in_ready  = 1'b1;
      (state == HOLD):  out_valid = 1'b1;
      default: ;
    endcase
  end

  // count wraps to 0 on the last beat so CW only needs to hold N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (state == ACCUM && flush) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (take) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
      if (last) begin
        count   <= '0;
        out_sum <= sum[ACC_W-1:0];
        out_ovf <= ovf | sum[ACC_W];
      end else begin
        count <= count + CW'(1);
      end
    end else if (handoff) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed and random checks of prod_accum against
// an integer-sum reference model.
module tb_prod_accum;

  localparam int N     = 4;
  localparam int ACC_W = 7;
  localparam int CW    = 4;
  localparam int M     = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       in_prod = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  int n_chk = 0;
  int n_err = 0;

  prod_accum #(.N(N), .ACC_W(ACC_W), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_prod(in_prod),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // phase: 0 waiting to start, 1 collecting, 2 result pending
  int m_ph;
  int m_cnt;
  int m_total;
  int m_rsum;
  int m_rovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph    <= 0;
      m_cnt   <= 0;
      m_total <= 0;
      m_rsum  <= 0;
      m_rovf  <= 0;
    end else begin
      case (m_ph)
        0: m_ph <= 1;
        1: begin
          if (flush) begin
            m_cnt   <= 0;
            m_total <= 0;
          end else if (in_valid) begin
            if (m_cnt == N-1) begin
              m_ph    <= 2;
              m_rsum  <= (m_total + int'(in_prod)) % M;
              m_rovf  <= ((m_total + int'(in_prod)) >= M) ? 1 : 0;
              m_cnt   <= 0;
              m_total <= 0;
            end else begin
              m_cnt   <= m_cnt + 1;
              m_total <= m_total + int'(in_prod);
            end
          end
        end
        default: if (out_ready) m_ph <= 1;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    chk("mdl_in_ready", int'(in_ready), (m_ph == 1) ? 1 : 0);
    chk("mdl_out_valid", int'(out_valid), (m_ph == 2) ? 1 : 0);
    chk("mdl_out_sum", int'(out_sum), m_rsum);
    chk("mdl_out_ovf", int'(out_ovf), m_rovf);
  end

  task automatic send(input int p);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 6'(p);
    flush    = 1'b0;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_rdy();
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("wait_in_ready_timeout", 0, 1);
  endtask

  task automatic group(input int a, input int b, input int c, input int d);
    wait_rdy();
    send(a);
    send(b);
    send(c);
    send(d);
    idle_in();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", int'(in_ready), 1);

    group(49, 12, 0, 35);
    chk("basic_valid", int'(out_valid), 1);
    chk("basic_in_ready", int'(in_ready), 0);
    chk("basic_sum", int'(out_sum), 96);
    chk("basic_ovf", int'(out_ovf), 0);
    @(negedge clk);
    chk("basic_valid_once", int'(out_valid), 0);
    chk("basic_sum_kept", int'(out_sum), 96);

    group(49, 49, 49, 49);
    chk("ovf_sum", int'(out_sum), 68);
    chk("ovf_flag", int'(out_ovf), 1);
    group(1, 1, 1, 1);
    chk("ovf_next_sum", int'(out_sum), 4);
    chk("ovf_next_flag", int'(out_ovf), 0);

    wait_rdy();
    out_ready = 1'b0;
    send(1);
    send(2);
    send(3);
    send(4);
    send(9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_sum", int'(out_sum), 10);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", int'(in_ready), 1);
    chk("bp_valid_drop", int'(out_valid), 0);
    send(1);
    send(1);
    send(1);
    idle_in();
    chk("bp_next_sum", int'(out_sum), 12);
    chk("bp_next_valid", int'(out_valid), 1);

    group(20, 30, 0, 0);
    wait_rdy();
    send(20);
    send(30);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 6'd7;
    flush    = 1'b1;
    send(1);
    send(2);
    send(3);
    send(4);
    idle_in();
    chk("flush_sum", int'(out_sum), 10);
    chk("flush_valid", int'(out_valid), 1);

    wait_rdy();
    send(5);
    send(5);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_sum", int'(out_sum), 0);
    chk("arst_ovf", int'(out_ovf), 0);
    #1 rst_n = 1'b1;
    group(2, 2, 2, 2);
    chk("arst_next_sum", int'(out_sum), 8);
    chk("arst_next_valid", int'(out_valid), 1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_prod   = 6'($urandom_range(0, 63));
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
    end
    idle_in();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
